// File: rtl/mips_defs.sv
// Shared MIPS constants and the fetch redirect priority used by the IF stage.
package mips_defs;

    localparam int unsigned XLEN = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_HOLD,
        PC_JUMP,
        PC_BRANCH
    } pc_sel_e;

    // Branch beats jump beats stall; a jump needs a real instruction in IF/ID.
    function automatic pc_sel_e pc_select(input logic branch_taken,
                                          input logic jump,
                                          input logic if_id_valid,
                                          input logic stall);
        pc_sel_e sel;
        if (branch_taken)              sel = PC_BRANCH;
        else if (jump && if_id_valid)  sel = PC_JUMP;
        else if (stall)                sel = PC_HOLD;
        else                           sel = PC_SEQ;
        return sel;
    endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter with next-PC mux; targets are forced word-aligned.
module pc_reg
    import mips_defs::*;
#(
    parameter int unsigned     WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  pc_sel_e          sel_i,
    input  logic [WIDTH-1:0] branch_target_i,
    input  logic [WIDTH-1:0] jump_target_i,
    output logic [WIDTH-1:0] pc_o
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        case (sel_i)
            PC_BRANCH: pc_d = branch_target_i & ALIGN_MASK;
            PC_JUMP:   pc_d = jump_target_i & ALIGN_MASK;
            PC_HOLD:   pc_d = pc_q;
            PC_SEQ:    pc_d = pc_q + WIDTH'(4);
            default:   pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= RESET_PC & ALIGN_MASK;
        else       pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, instruction-memory address and the IF/ID register.
module if_stage
#(
    parameter logic [31:0]  RESET_PC = mips_defs::RESET_PC,
    parameter int unsigned  WIDTH    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] imemAddr,
    input  logic [WIDTH-1:0] imemData,
    input  logic             stall,
    input  logic             jump,
    input  logic             branchTaken,
    input  logic [WIDTH-1:0] branchTarget,
    output logic [WIDTH-1:0] ifIdInstr,
    output logic [WIDTH-1:0] ifIdPcPlus4,
    output logic             ifIdValid,
    output logic [5:0]       opCode,
    output logic [WIDTH-1:0] fetchCount
);

    mips_defs::pc_sel_e sel;

    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] jump_target;

    assign sel         = mips_defs::pc_select(branchTaken, jump, valid_q, stall);
    assign pc_plus4    = imemAddr + WIDTH'(4);
    assign jump_target = {pc4_q[WIDTH-1:WIDTH-4], instr_q[25:0], 2'b00};

    pc_reg #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .reset           (reset),
        .sel_i           (sel),
        .branch_target_i (branchTarget),
        .jump_target_i   (jump_target),
        .pc_o            (imemAddr)
    );

    // A redirect injects exactly one bubble; a bubble looks like the reset state.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        count_d = count_q;
        case (sel)
            mips_defs::PC_BRANCH,
            mips_defs::PC_JUMP: begin
                instr_d = mips_defs::NOP_INSTR;
                pc4_d   = '0;
                valid_d = 1'b0;
            end
            mips_defs::PC_SEQ: begin
                instr_d = imemData;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
                count_d = count_q + WIDTH'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= mips_defs::NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign ifIdInstr   = instr_q;
    assign ifIdPcPlus4 = pc4_q;
    assign ifIdValid   = valid_q;
    assign opCode      = instr_q[31:26];
    assign fetchCount  = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage with a small combinational instruction memory.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic        stall;
    logic        jump;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic [31:0] ifIdInstr;
    logic [31:0] ifIdPcPlus4;
    logic        ifIdValid;
    logic [5:0]  opCode;
    logic [31:0] fetchCount;

    int errors = 0;
    int checks = 0;

    if_stage #(.RESET_PC(32'h0000_0000), .WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .imemAddr     (imemAddr),
        .imemData     (imemData),
        .stall        (stall),
        .jump         (jump),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .ifIdInstr    (ifIdInstr),
        .ifIdPcPlus4  (ifIdPcPlus4),
        .ifIdValid    (ifIdValid),
        .opCode       (opCode),
        .fetchCount   (fetchCount)
    );

    always #5 clk = ~clk;

    // Program image: a few fixed words, everything else an addi tagged with its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h8C01_0004;
            32'h0000_0004: return 32'h0800_0010;
            32'h0000_0040: return 32'hAC03_0040;
            32'h0000_0100: return 32'h1000_0005;
            default:       return {6'b001000, a[25:0]};
        endcase
    endfunction

    always_comb imemData = mem_word(imemAddr);

    typedef struct {
        logic        stall;
        logic        jump;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        chk_pc4;
        logic        valid;
        logic [31:0] cnt;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic s, input logic j, input logic b, input logic [31:0] t);
        stall = s; jump = j; branchTaken = b; branchTarget = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        vt[0] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0004, 32'h8C01_0004, 32'h0000_0004, 1'b1, 1'b1, 32'd1};
        vt[1] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0008, 32'h0800_0010, 32'h0000_0008, 1'b1, 1'b1, 32'd2};
        vt[2] = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h0000_0040, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'd2};
        vt[3] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0044, 32'hAC03_0040, 32'h0000_0044, 1'b1, 1'b1, 32'd3};
        vt[4] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0044, 32'hAC03_0040, 32'h0000_0044, 1'b1, 1'b1, 32'd3};
        vt[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_0103, 32'h0000_0100, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'd3};
        vt[6] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0104, 32'h1000_0005, 32'h0000_0104, 1'b1, 1'b1, 32'd4};
        vt[7] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'd4};
        vt[8] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0000, 32'h23FF_FFFC, 32'h0000_0000, 1'b1, 1'b1, 32'd5};
        vt[9] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0004, 32'h8C01_0004, 32'h0000_0004, 1'b1, 1'b1, 32'd6};

        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        #2;
        chk("reset_addr",  imemAddr,   32'h0);
        chk("reset_instr", ifIdInstr,  32'h0);
        chk("reset_pc4",   ifIdPcPlus4, 32'h0);
        chk("reset_valid", 32'(ifIdValid), 32'h0);
        chk("reset_op",    32'(opCode), 32'h0);
        chk("reset_cnt",   fetchCount, 32'h0);
        step();
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            logic [31:0] ei;
            set_in(vt[i].stall, vt[i].jump, vt[i].br, vt[i].tgt);
            step();
            ei = vt[i].instr;
            chk($sformatf("v%0d_addr", i),  imemAddr,  vt[i].addr);
            chk($sformatf("v%0d_instr", i), ifIdInstr, ei);
            chk($sformatf("v%0d_op", i),    32'(opCode), 32'(ei[31:26]));
            if (vt[i].chk_pc4)
                chk($sformatf("v%0d_pc4", i), ifIdPcPlus4, vt[i].pc4);
            chk($sformatf("v%0d_valid", i), 32'(ifIdValid), 32'(vt[i].valid));
            chk($sformatf("v%0d_cnt", i),   fetchCount, vt[i].cnt);
        end

        // Two-cycle stall with PC=8 and the j sitting in IF/ID, then release.
        do_reset();
        step();
        step();
        chk("st_pre_addr", imemAddr, 32'h0000_0008);
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("st%0d_addr", k),  imemAddr,  32'h0000_0008);
            chk($sformatf("st%0d_instr", k), ifIdInstr, 32'h0800_0010);
            chk($sformatf("st%0d_cnt", k),   fetchCount, 32'd2);
        end
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("st_rel_addr",  imemAddr,   32'h0000_000C);
        chk("st_rel_instr", ifIdInstr,  32'h2000_0008);
        chk("st_rel_cnt",   fetchCount, 32'd3);

        // Asynchronous reset in mid-cycle at PC=0x20 with jump pending.
        do_reset();
        for (int k = 0; k < 8; k++) step();
        chk("ar_pre_addr",  imemAddr, 32'h0000_0020);
        chk("ar_pre_valid", 32'(ifIdValid), 32'h1);
        jump = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_addr",  imemAddr, 32'h0);
        chk("ar_valid", 32'(ifIdValid), 32'h0);
        chk("ar_op",    32'(opCode), 32'h0);
        chk("ar_cnt",   fetchCount, 32'h0);
        #1;
        reset = 1'b0;
        step();
        chk("ar_post_addr",  imemAddr,  32'h0000_0004);
        chk("ar_post_instr", ifIdInstr, 32'h8C01_0004);
        chk("ar_post_valid", 32'(ifIdValid), 32'h1);
        chk("ar_post_cnt",   fetchCount, 32'd1);
        jump = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
